// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states and tick divider helper
package uart_pkg;
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_e;
  localparam int OS = 16;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OS / 2)) / (baud * OS);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small sync byte FIFO with registered head, overrun pulse and simultaneous push/pop
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     valid_o,
  output logic                     overrun_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] lvl_q;
  logic ovr_q, full, empty, do_pop, do_push;
  assign empty = lvl_q == '0;
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i && !empty;
  // a pop frees the slot the same cycle, so a full FIFO still accepts a push
  assign do_push = push_i && (!full || do_pop);
  always_ff @(posedge clk)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      lvl_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ovr_q <= push_i && full && !do_pop;
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  assign head_o = mem_q[rd_q];
  assign valid_o = !empty;
  assign overrun_o = ovr_q;
  assign level_o = lvl_q;
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampling with 3-sample majority, FIFO-buffered byte stream
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd_i,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  state_e state_q;
  logic s1_q, line_q, hist_q, frame_err_q;
  logic [DW-1:0] div_q;
  logic [3:0] phase_q;
  logic [2:0] bit_q;
  logic [1:0] smp_q;
  logic [7:0] shift_q;
  logic tick, fall, start, maj, at_mid, end_bit, push;
  always_ff @(posedge clk)
    if (rst) {s1_q, line_q, hist_q} <= 3'b111;
    else {s1_q, line_q, hist_q} <= {rxd_i, s1_q, line_q};
  assign tick = div_q == DW'(DIV - 1);
  assign fall = hist_q && !line_q;
  assign start = state_q == IDLE && fall;
  assign at_mid = tick && phase_q == 4'd9;
  assign end_bit = tick && phase_q == LAST;
  // phases 7 and 8 are held in smp_q, phase 9 is the live line
  assign maj = (smp_q[0] && smp_q[1]) || (line_q && (smp_q[0] || smp_q[1]));
  assign push = state_q == STOP && at_mid && maj;
  always_ff @(posedge clk)
    if (rst || start) div_q <= '0;
    else div_q <= tick ? '0 : div_q + DW'(1);
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= WAIT_IDLE;
      phase_q <= '0;
      bit_q <= '0;
      smp_q <= '0;
      shift_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (tick && (phase_q == 4'd7 || phase_q == 4'd8)) smp_q <= {smp_q[0], line_q};
      if (tick) phase_q <= phase_q + 4'd1;
      case (state_q)
        WAIT_IDLE:
          if (!line_q) phase_q <= '0;
          else if (end_bit) state_q <= IDLE;
        IDLE:
          if (fall) begin
            state_q <= START;
            phase_q <= '0;
          end
        START:
          if (at_mid && maj) state_q <= IDLE;
          else if (end_bit) begin
            state_q <= DATA;
            bit_q <= '0;
          end
        DATA: begin
          if (at_mid) shift_q <= {maj, shift_q[7:1]};
          if (end_bit) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        STOP:
          if (at_mid) begin
            state_q <= maj ? IDLE : WAIT_IDLE;
            frame_err_q <= !maj;
            if (!maj) phase_q <= '0;
          end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .data_i(shift_q),
    .pop_i(out_ready),
    .head_o(out_data),
    .valid_o(out_valid),
    .overrun_o(overrun),
    .level_o(fifo_level)
  );
  assign frame_err = frame_err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and randomized frames checked against a byte-queue model of the receiver
`timescale 1ns/1ps
module tb_uart_byte_rx;
  localparam real TCLK = 37.04;
  localparam real BIT_NOM = 8680.56;
  // receiver's own bit period (16 ticks of 15 clocks); rate tolerance is judged around it
  localparam real BIT_RX = 16.0 * 15.0 * TCLK;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, out_ready = 1'b1;
  logic out_valid, frame_err, overrun, busy;
  logic [7:0] out_data;
  logic [2:0] fifo_level;
  int n_cmp = 0, n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  int got_base = 0, fe_base = 0, ov_base = 0;
  int exp_fe = 0, exp_ov = 0, held = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #(TCLK / 2) clk = ~clk;

  uart_byte_rx dut (
    .clk(clk), .rst(rst), .rxd_i(rxd), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun),
    .fifo_level(fifo_level), .busy(busy)
  );

  always @(negedge clk)
    if (!rst) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input real bt, input logic stop_bit, input int rst_at);
    rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == rst_at) begin
        #(bt / 2);
        rst = 1'b1;
        #(4 * TCLK);
        rst = 1'b0;
        #(bt / 2 - 4 * TCLK);
      end else #(bt);
    end
    rxd = stop_bit;
    #(bt);
    rxd = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input real bt, input logic stop_bit);
    if (!stop_bit) exp_fe++;
    else if (!out_ready && held == 4) exp_ov++;
    else begin
      exp_q.push_back(b);
      if (!out_ready) held++;
    end
    drive(b, bt, stop_bit, -1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_base + i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[got_base + i], exp_q[i]);
    chk({tag, "_frame_err"}, fe_cnt - fe_base, exp_fe);
    chk({tag, "_overrun"}, ov_cnt - ov_base, exp_ov);
    chk({tag, "_err_overlap"}, both_cnt, 0);
    got_base = got.size();
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    exp_q.delete();
    exp_fe = 0;
    exp_ov = 0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 1);
    settle(300);
    chk("idle_busy", busy, 0);

    frame(8'h55, BIT_NOM, 1'b1);
    settle(20);
    check_stream("t1");

    frame(8'hA5, BIT_NOM, 1'b1);
    frame(8'h00, BIT_NOM, 1'b1);
    frame(8'hFF, BIT_NOM, 1'b1);
    settle(20);
    check_stream("t2");

    rxd = 1'b0;
    #(1900);
    chk("t3_busy_start", busy, 1);
    #(100);
    rxd = 1'b1;
    for (int i = 0; i < 234 && busy; i++) @(negedge clk);
    chk("t3_busy_idle", busy, 0);
    settle(300);
    check_stream("t3");

    frame(8'h3C, BIT_NOM, 1'b0);
    #(2 * BIT_NOM);
    frame(8'h81, BIT_NOM, 1'b1);
    settle(20);
    check_stream("t4");

    @(posedge clk);
    #1 out_ready = 1'b0;
    held = 0;
    for (int k = 1; k <= 5; k++) frame(8'(k), BIT_NOM, 1'b1);
    settle(20);
    chk("t5_level", fifo_level, 4);
    chk("t5_valid", out_valid, 1);
    chk("t5_head", out_data, 8'h01);
    out_ready = 1'b1;
    settle(10);
    chk("t5_drained", fifo_level, 0);
    check_stream("t5");

    out_ready = 1'b0;
    held = 0;
    frame(8'h77, BIT_NOM, 1'b1);
    settle(20);
    chk("t6_prefill", fifo_level, 1);
    drive(8'hF0, BIT_NOM, 1'b1, 3);
    exp_q.delete();
    held = 0;
    settle(5);
    chk("t6_flush_level", fifo_level, 0);
    chk("t6_flush_valid", out_valid, 0);
    #(BIT_NOM);
    frame(8'h42, BIT_NOM, 1'b1);
    settle(20);
    chk("t6_level", fifo_level, 1);
    chk("t6_head", out_data, 8'h42);
    out_ready = 1'b1;
    settle(10);
    check_stream("t6");

    frame(8'h55, BIT_RX / 1.03, 1'b1);
    #(BIT_NOM);
    frame(8'h55, BIT_RX / 0.97, 1'b1);
    settle(20);
    check_stream("t7");

    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      real bt;
      b = 8'($urandom);
      bt = BIT_RX * (0.98 + 0.04 * real'($urandom_range(0, 100)) / 100.0);
      frame(b, bt, 1'b1);
      #(real'($urandom_range(0, 2)) * BIT_NOM / 2);
    end
    settle(20);
    check_stream("rand");

    rxd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    settle(3);
    rst = 1'b0;
    #(3 * BIT_NOM);
    chk("break_busy", busy, 1);
    chk("break_level", fifo_level, 0);
    check_stream("break");
    rxd = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
